sequence_match_counter: RTL and testbench

- Downstream consumer of the sequence detector's 2-bit `result` code.
- Counts detections per pattern in saturating counters and emits a one-cycle match strobe.
- Drives a 4-digit multiplexed seven-segment display with the low bytes of both counts, so detector activity is visible on the board.
- Sits between the detector and the board-level display pins.

---
 rtl/sequence_match_counter_pkg.sv | 30 +++
 rtl/sequence_match_counter_if.sv | 23 ++
 rtl/sequence_match_counter_hex_to_seven_seg.sv | 9 +
 rtl/sequence_match_counter.sv | 117 +++++++++++
 tb/tb_sequence_match_counter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sequence_match_counter_pkg.sv
// Shared constants for the sequence-match counter and its display path:
// detector result codes, scan state encoding and hex seven-segment patterns.
package sequence_match_counter_pkg;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_A    = 2'b01;
  localparam logic [1:0] RES_B    = 2'b10;
  localparam logic [1:0] RES_AB   = 2'b11;

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;
  localparam logic [1:0] DIG3 = 2'd3;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits at the right-hand end.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam logic [6:0] SEG_HEX0 = 7'b1000000;

endpackage

// File: rtl/sequence_match_counter_if.sv
// Detector-side inputs and display/count outputs of the match counter.
interface sequence_match_counter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       result;
  logic             clear;
  logic [WIDTH-1:0] countA;
  logic [WIDTH-1:0] countB;
  logic             matchPulse;
  logic             saturated;
  logic [3:0]       anode;
  logic [6:0]       segment;

  modport master (
    output result, clear,
    input  countA, countB, matchPulse, saturated, anode, segment
  );

  modport slave (
    input  result, clear,
    output countA, countB, matchPulse, saturated, anode, segment
  );
endinterface

// File: rtl/sequence_match_counter_hex_to_seven_seg.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seven_seg
  import sequence_match_counter_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_PAT[digit_i];
endmodule

// File: rtl/sequence_match_counter.sv
// Saturating per-pattern detection counters, registered match strobe and a
// 4-digit multiplexed seven-segment scan of the low count bytes.
module sequence_match_counter
  import sequence_match_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clockPulse,
  input  logic               reset,
  sequence_match_counter_if.slave bus
);

  localparam int               DW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0]    DIV_END = DW'(SCAN_DIV - 1);

  logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic             sat_q, sat_d;
  logic             match_q, match_d;
  logic [DW-1:0]    div_q, div_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       nib;
  logic             hit_a, hit_b;

  assign hit_a = (bus.result == RES_A) || (bus.result == RES_AB);
  assign hit_b = (bus.result == RES_B) || (bus.result == RES_AB);

  // clear wins over a same-cycle detection, which is then dropped.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    sat_d   = sat_q;
    match_d = 1'b0;
    if (bus.clear) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (hit_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + WIDTH'(1);
      if (hit_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + WIDTH'(1);
      match_d = (bus.result != RES_NONE);
      sat_d   = sat_q | (cnt_a_d == CNT_MAX) | (cnt_b_d == CNT_MAX);
    end
  end

  always_ff @(posedge clockPulse or negedge reset) begin
    if (!reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      sat_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      sat_q   <= sat_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    div_d   = div_q + DW'(1);
    state_d = state_q;
    if (div_q == DIV_END) begin
      div_d = '0;
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end
  end

  // Digit source and anode follow the current state; both are then
  // registered, so the visible digit trails the count by one cycle.
  always_comb begin
    nib     = cnt_a_q[3:0];
    anode_d = AN_DIG0;
    case (state_q)
      DIG0:    begin nib = cnt_a_q[3:0]; anode_d = AN_DIG0; end
      DIG1:    begin nib = cnt_a_q[7:4]; anode_d = AN_DIG1; end
      DIG2:    begin nib = cnt_b_q[3:0]; anode_d = AN_DIG2; end
      default: begin nib = cnt_b_q[7:4]; anode_d = AN_DIG3; end
    endcase
  end

  hex_to_seven_seg u_hex (
    .digit_i (nib),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clockPulse or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      state_q <= DIG0;
      anode_q <= AN_DIG0;
      seg_q   <= SEG_HEX0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.countA     = cnt_a_q;
  assign bus.countB     = cnt_b_q;
  assign bus.matchPulse = match_q;
  assign bus.saturated  = sat_q;
  assign bus.anode      = anode_q;
  assign bus.segment    = seg_q;

endmodule

// File: tb/tb_sequence_match_counter.sv
// Directed bench for sequence_match_counter with WIDTH=8, SCAN_DIV=4.
module tb_sequence_match_counter;

  logic clockPulse;
  logic reset;
  int   checks;
  int   failures;

  sequence_match_counter_if #(.WIDTH(8)) bus ();

  sequence_match_counter #(.WIDTH(8), .SCAN_DIV(4)) dut (
    .clockPulse (clockPulse),
    .reset      (reset),
    .bus        (bus)
  );

  initial begin
    clockPulse = 1'b0;
    forever #5 clockPulse = ~clockPulse;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clockPulse);
  endtask

  task automatic drive(input logic [1:0] r, input logic c, input int n);
    bus.result = r;
    bus.clear  = c;
    tick(n);
  endtask

  initial begin
    logic [3:0] an_exp  [4];
    logic [6:0] seg_exp [4];
    logic [3:0] an_prev;
    bit         found;

    an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
    seg_exp[0] = 7'b1000110; seg_exp[1] = 7'b0110000;
    seg_exp[2] = 7'b0010010; seg_exp[3] = 7'b0001000;
    checks = 0;
    failures = 0;

    reset = 1'b0;
    bus.result = 2'b00;
    bus.clear  = 1'b0;
    tick(3);
    chk("rst_countA", 32'(bus.countA), 0);
    chk("rst_countB", 32'(bus.countB), 0);
    chk("rst_match", 32'(bus.matchPulse), 0);
    chk("rst_sat", 32'(bus.saturated), 0);
    chk("rst_anode", 32'(bus.anode), 32'b1110);
    chk("rst_segment", 32'(bus.segment), 32'b1000000);

    reset = 1'b1;
    drive(2'b01, 1'b0, 1);
    chk("seq01_A", 32'(bus.countA), 1);
    chk("seq01_mp", 32'(bus.matchPulse), 1);
    drive(2'b10, 1'b0, 1);
    chk("seq10_B", 32'(bus.countB), 1);
    chk("seq10_mp", 32'(bus.matchPulse), 1);
    drive(2'b11, 1'b0, 1);
    chk("seq11_A", 32'(bus.countA), 2);
    chk("seq11_B", 32'(bus.countB), 2);
    chk("seq11_mp", 32'(bus.matchPulse), 1);
    drive(2'b00, 1'b0, 1);
    chk("seq00_A", 32'(bus.countA), 2);
    chk("seq00_B", 32'(bus.countB), 2);
    chk("seq00_mp", 32'(bus.matchPulse), 0);
    tick(1);
    chk("seq_idle_mp", 32'(bus.matchPulse), 0);

    // Saturation: 259 cycles of pattern A from zero.
    drive(2'b00, 1'b1, 1);
    drive(2'b01, 1'b0, 254);
    chk("sat_A254", 32'(bus.countA), 254);
    chk("sat_pre", 32'(bus.saturated), 0);
    drive(2'b01, 1'b0, 1);
    chk("sat_A255", 32'(bus.countA), 255);
    chk("sat_set", 32'(bus.saturated), 1);
    drive(2'b01, 1'b0, 4);
    chk("sat_hold_A", 32'(bus.countA), 255);
    chk("sat_hold_B", 32'(bus.countB), 0);
    drive(2'b00, 1'b0, 2);
    chk("sat_sticky", 32'(bus.saturated), 1);
    chk("sat_idle_A", 32'(bus.countA), 255);

    // clear beats a simultaneous 11 and drops the saturated flag.
    drive(2'b11, 1'b1, 1);
    chk("clr1_A", 32'(bus.countA), 0);
    chk("clr1_B", 32'(bus.countB), 0);
    chk("clr1_sat", 32'(bus.saturated), 0);
    chk("clr1_mp", 32'(bus.matchPulse), 0);
    drive(2'b11, 1'b0, 3);
    drive(2'b01, 1'b0, 2);
    chk("pre_clr_A", 32'(bus.countA), 5);
    chk("pre_clr_B", 32'(bus.countB), 3);
    drive(2'b11, 1'b1, 1);
    chk("clr2_A", 32'(bus.countA), 0);
    chk("clr2_B", 32'(bus.countB), 0);
    chk("clr2_sat", 32'(bus.saturated), 0);

    // Display: countA=0x3C, countB=0xA5.
    drive(2'b11, 1'b0, 60);
    drive(2'b10, 1'b0, 105);
    drive(2'b00, 1'b0, 2);
    chk("disp_A", 32'(bus.countA), 32'h3C);
    chk("disp_B", 32'(bus.countB), 32'hA5);
    found = 1'b0;
    an_prev = bus.anode;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (an_prev != 4'b1110 && bus.anode == 4'b1110) found = 1'b1;
      else an_prev = bus.anode;
    end
    chk("disp_sync", 32'(found), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("disp_an%0d", i), 32'(bus.anode), 32'(an_exp[i / 4]));
      chk($sformatf("disp_seg%0d", i), 32'(bus.segment), 32'(seg_exp[i / 4]));
      tick(1);
    end

    // Asynchronous reset between edges.
    drive(2'b01, 1'b0, 10);
    #2 reset = 1'b0;
    #1;
    chk("arst_A", 32'(bus.countA), 0);
    chk("arst_B", 32'(bus.countB), 0);
    chk("arst_mp", 32'(bus.matchPulse), 0);
    chk("arst_sat", 32'(bus.saturated), 0);
    chk("arst_anode", 32'(bus.anode), 32'b1110);
    chk("arst_seg", 32'(bus.segment), 32'b1000000);
    @(negedge clockPulse);

    // Release together with result=10.
    reset = 1'b1;
    drive(2'b10, 1'b0, 1);
    chk("rel_B", 32'(bus.countB), 1);
    chk("rel_A", 32'(bus.countA), 0);
    chk("rel_mp", 32'(bus.matchPulse), 1);
    drive(2'b00, 1'b0, 1);
    chk("rel_hold_B", 32'(bus.countB), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
